// File: rtl/top_block_code_decoder.sv
// Soft-decision ML decoder for the (20,A) Reed-Muller block code, A = 1..13.
// Symbols are collected into a fill buffer, handed to a single pending slot,
// and searched exhaustively (one candidate per cycle) by the engine.
// Optional feature macro: BLOCK_CODE_METRIC_EN adds o_best_metric.
module top_block_code_decoder #(
    parameter int DATA_WIDTH = 4,
    parameter int N_CODE     = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_symbols,
    input  logic                  i_rx_symbols_valid,
    input  logic [3:0]            i_code_length,
    output logic [12:0]           o_decoded_bits,
    output logic                  o_decoded_valid,
    output logic                  o_busy,
    output logic                  o_overflow
`ifdef BLOCK_CODE_METRIC_EN
    ,
    output logic [9:0]            o_best_metric
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DONE} state_t;

    localparam logic [4:0]        LAST_IDX     = 5'(N_CODE - 1);
    localparam logic signed [9:0] METRIC_FLOOR = 10'sh200;

    // Basis sequences: bit i of row n is M_i,n.
    function automatic logic [12:0] basis_row(input logic [4:0] n);
        case (n)
            5'd0:    basis_row = 13'b0110000000011;
            5'd1:    basis_row = 13'b0111000000111;
            5'd2:    basis_row = 13'b1111101001001;
            5'd3:    basis_row = 13'b1110100001101;
            5'd4:    basis_row = 13'b1110010001111;
            5'd5:    basis_row = 13'b1110111010011;
            5'd6:    basis_row = 13'b1111101010101;
            5'd7:    basis_row = 13'b1110110011001;
            5'd8:    basis_row = 13'b1111010011011;
            5'd9:    basis_row = 13'b1111001011101;
            5'd10:   basis_row = 13'b1111011100101;
            5'd11:   basis_row = 13'b1110101100111;
            5'd12:   basis_row = 13'b1111110101001;
            5'd13:   basis_row = 13'b1111010101011;
            5'd14:   basis_row = 13'b1010010110001;
            5'd15:   basis_row = 13'b1011011110011;
            5'd16:   basis_row = 13'b1101001110111;
            5'd17:   basis_row = 13'b1100100111001;
            5'd18:   basis_row = 13'b0000011111011;
            5'd19:   basis_row = 13'b0000001100001;
            default: basis_row = 13'b0000000000000;
        endcase
    endfunction

    // A = 0 behaves as 1, anything above 13 behaves as 13.
    function automatic logic [3:0] clamp_len(input logic [3:0] a);
        if (a == 4'd0) begin
            clamp_len = 4'd1;
        end else if (a > 4'd13) begin
            clamp_len = 4'd13;
        end else begin
            clamp_len = a;
        end
    endfunction

    function automatic logic signed [9:0] sext(input logic [DATA_WIDTH-1:0] s);
        sext = {{(10 - DATA_WIDTH){s[DATA_WIDTH-1]}}, s};
    endfunction

    logic [4:0]            r_cnt;
    logic                  r_commit;
    logic [3:0]            r_fill_a;
    logic [DATA_WIDTH-1:0] r_fill [0:N_CODE-1];
    logic                  r_pend_full;
    logic [3:0]            r_pend_a;
    logic [DATA_WIDTH-1:0] r_pend [0:N_CODE-1];
    logic                  r_overflow;
    state_t                r_state;
    logic [3:0]            r_work_a;
    logic [DATA_WIDTH-1:0] r_work [0:N_CODE-1];
    logic [12:0]           r_cand;
    logic [12:0]           r_best;
    logic signed [9:0]     r_best_metric;
    logic [12:0]           r_decoded_bits;
    logic                  r_decoded_valid;
    logic                  r_busy;
`ifdef BLOCK_CODE_METRIC_EN
    logic signed [9:0]     r_out_metric;
`endif

    logic                  w_load;
    logic [13:0]           w_cand_last;
    logic [N_CODE-1:0]     w_cbits;
    logic signed [9:0]     w_metric;

    assign w_load      = (r_state == ST_IDLE) && r_pend_full;
    assign w_cand_last = (14'd1 << r_work_a) - 14'd1;

    // Codeword bits of the current candidate; cand never has bits at or above A.
    always_comb begin
        w_cbits = '0;
        for (int n = 0; n < N_CODE; n++) begin
            w_cbits[n] = ^(r_cand & basis_row(5'(n)));
        end
    end

    // Correlation of the work buffer against the candidate codeword, one combinational sum.
    always_comb begin
        w_metric = 10'sd0;
        for (int n = 0; n < N_CODE; n++) begin
            w_metric = w_metric + (w_cbits[n] ? -sext(r_work[n]) : sext(r_work[n]));
        end
    end

    // Symbol collection into the fill buffer; flags a commit after symbol 19.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt    <= 5'd0;
            r_commit <= 1'b0;
            r_fill_a <= 4'd1;
            for (int n = 0; n < N_CODE; n++) begin
                r_fill[n] <= '0;
            end
        end else begin
            r_commit <= 1'b0;
            if (i_rx_symbols_valid) begin
                r_fill[r_cnt] <= i_rx_symbols;
                if (r_cnt == 5'd0) begin
                    r_fill_a <= clamp_len(i_code_length);
                end
                if (r_cnt == LAST_IDX) begin
                    r_cnt    <= 5'd0;
                    r_commit <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 5'd1;
                end
            end
        end
    end

    // Pending slot: filled by a commit, freed by the engine load, drop on collision.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pend_full <= 1'b0;
            r_pend_a    <= 4'd1;
            r_overflow  <= 1'b0;
            for (int n = 0; n < N_CODE; n++) begin
                r_pend[n] <= '0;
            end
        end else begin
            if (r_commit) begin
                if (r_pend_full && !w_load) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pend      <= r_fill;
                    r_pend_a    <= r_fill_a;
                    r_pend_full <= 1'b1;
                end
            end else if (w_load) begin
                r_pend_full <= 1'b0;
            end
        end
    end

    // Search engine: load, exhaustive candidate scan, then register the winner.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state         <= ST_IDLE;
            r_work_a        <= 4'd1;
            r_cand          <= 13'd0;
            r_best          <= 13'd0;
            r_best_metric   <= 10'sd0;
            r_decoded_bits  <= 13'd0;
            r_decoded_valid <= 1'b0;
            r_busy          <= 1'b0;
            for (int n = 0; n < N_CODE; n++) begin
                r_work[n] <= '0;
            end
`ifdef BLOCK_CODE_METRIC_EN
            r_out_metric    <= 10'sd0;
`endif
        end else begin
            r_decoded_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_work        <= r_pend;
                        r_work_a      <= r_pend_a;
                        r_cand        <= 13'd0;
                        r_best        <= 13'd0;
                        r_best_metric <= METRIC_FLOOR;
                        r_busy        <= 1'b1;
                        r_state       <= ST_SEARCH;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_SEARCH: begin
                    // Strictly greater keeps the lowest candidate on ties.
                    if (w_metric > r_best_metric) begin
                        r_best_metric <= w_metric;
                        r_best        <= r_cand;
                    end
                    if ({1'b0, r_cand} == w_cand_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cand <= r_cand + 13'd1;
                    end
                end
                ST_DONE: begin
                    r_decoded_bits  <= r_best;
                    r_decoded_valid <= 1'b1;
`ifdef BLOCK_CODE_METRIC_EN
                    r_out_metric    <= r_best_metric;
`endif
                    r_state         <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_decoded_bits  = r_decoded_bits;
    assign o_decoded_valid = r_decoded_valid;
    assign o_busy          = r_busy;
    assign o_overflow      = r_overflow;
`ifdef BLOCK_CODE_METRIC_EN
    assign o_best_metric   = r_out_metric;
`endif

endmodule

// File: tb/tb_top_block_code_decoder.sv
// Bench for top_block_code_decoder: directed cases plus randomized frames,
// checked against an exhaustive ML reference computed from the basis table.
module tb_top_block_code_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rx;
    logic        rx_v;
    logic [3:0]  cl;
    logic [12:0] dbits;
    logic        dv;
    logic        busy;
    logic        ovf;
`ifdef BLOCK_CODE_METRIC_EN
    logic [9:0]  bm;
`endif

    always #5 clk = ~clk;

    top_block_code_decoder dut (
        .i_clk              (clk),
        .i_rst              (rst_n),
        .i_rx_symbols       (rx),
        .i_rx_symbols_valid (rx_v),
        .i_code_length      (cl),
        .o_decoded_bits     (dbits),
        .o_decoded_valid    (dv),
        .o_busy             (busy),
        .o_overflow         (ovf)
`ifdef BLOCK_CODE_METRIC_EN
        ,
        .o_best_metric      (bm)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int sym [20];

    // Rows as printed in the standard: leftmost bit is M0, rightmost is M12.
    logic [12:0] rows [20] = '{
        13'b1100000000110, 13'b1110000001110, 13'b1001001011111, 13'b1011000010111,
        13'b1111000100111, 13'b1100101110111, 13'b1010101011111, 13'b1001100110111,
        13'b1101100101111, 13'b1011101001111, 13'b1010011101111, 13'b1110011010111,
        13'b1001010111111, 13'b1101010101111, 13'b1000110100101, 13'b1100111101101,
        13'b1110111001011, 13'b1001110010011, 13'b1101111100000, 13'b1000011000000
    };

    int got_bits [$];
    int got_cyc [$];
    int got_busy [$];
    int got_metric [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (dv === 1'b1) begin
            got_bits.push_back(int'(dbits));
            got_cyc.push_back(cyc);
            got_busy.push_back(int'(busy));
`ifdef BLOCK_CODE_METRIC_EN
            got_metric.push_back(int'($signed(bm)));
`else
            got_metric.push_back(0);
`endif
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int eff_len(input int a);
        if (a == 0) return 1;
        if (a > 13) return 13;
        return a;
    endfunction

    function automatic int cw_bit(input int w, input int a, input int n);
        int b = 0;
        for (int i = 0; i < a; i++) begin
            if (((w >> i) & 1) == 1 && rows[n][12 - i] == 1'b1) b ^= 1;
        end
        return b;
    endfunction

    // Exhaustive maximum-likelihood search over the current frame in sym[].
    task automatic model(input int a, output int word, output int metric);
        int e = eff_len(a);
        int best = -100000;
        int bw = 0;
        for (int w = 0; w < (1 << e); w++) begin
            int c = 0;
            for (int n = 0; n < 20; n++) begin
                c += (cw_bit(w, e, n) == 1) ? -sym[n] : sym[n];
            end
            if (c > best) begin
                best = c;
                bw = w;
            end
        end
        word = bw;
        metric = best;
    endtask

    task automatic encode(input int info, input int a);
        for (int n = 0; n < 20; n++) sym[n] = (cw_bit(info, eff_len(a), n) == 1) ? -8 : 7;
    endtask

    task automatic flip(input int n);
        sym[n] = (sym[n] == 7) ? -8 : 7;
    endtask

    task automatic clear_q();
        got_bits.delete();
        got_cyc.delete();
        got_busy.delete();
        got_metric.delete();
    endtask

    // Drive the first nsym symbols of sym[]; valid is left high afterwards.
    task automatic drive_frame(input int a, input int nsym, input int rnd);
        for (int n = 0; n < nsym; n++) begin
            if (rnd != 0 && n > 0 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    rx_v = 1'b0;
                end
            end
            @(negedge clk);
            rx   = 4'(sym[n]);
            rx_v = 1'b1;
            cl   = (n == 0 || rnd == 0) ? 4'(a) : 4'($urandom_range(0, 15));
            if (n == 19) last_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_v = 1'b0;
        end
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (got_bits.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (got_bits.size() < n) check("strobe_timeout", got_bits.size(), n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_v  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
    endtask

    // One frame through an idle engine: word, metric, latency, busy, single strobe.
    task automatic run_single(input string tag, input int a, input int rnd, input int exp_const);
        int ew, em, accept, e;
        e = eff_len(a);
        model(a, ew, em);
        clear_q();
        drive_frame(a, 20, rnd);
        accept = last_cyc + 1;
        idle(1);
        wait_strobes(1, (1 << e) + 40);
        if (got_bits.size() >= 1) begin
            check({tag, "_bits"}, got_bits[0], ew);
            check({tag, "_latency"}, got_cyc[0] - accept, (1 << e) + 3);
            check({tag, "_busy_at_strobe"}, got_busy[0], 1);
`ifdef BLOCK_CODE_METRIC_EN
            check({tag, "_metric"}, got_metric[0], em);
`endif
            if (exp_const >= 0) check({tag, "_const"}, got_bits[0], exp_const);
        end
        idle(30);
        check({tag, "_strobe_count"}, got_bits.size(), 1);
        check({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int w1, w2, m1, m2, i1, i2, a;
        rst_n = 1'b0;
        rx    = 4'd0;
        rx_v  = 1'b0;
        cl    = 4'd0;
        repeat (2) @(negedge clk);

        check("reset_bits", int'(dbits), 0);
        check("reset_valid", int'(dv), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overflow", int'(ovf), 0);
        do_reset();

        // Noiseless A=4.
        encode(4'b1011, 4);
        run_single("noiseless_a4", 4, 0, 13'h00B);

        // Two sign flips on a 13-bit codeword.
        encode(13'h1A5, 13);
        flip(3);
        flip(11);
        run_single("flips_a13", 13, 0, -1);

        // All-zero symbols: every candidate ties, lowest wins.
        for (int n = 0; n < 20; n++) sym[n] = 0;
        run_single("tie_a6", 6, 0, 0);

        // Length clamping.
        encode(13'h0F0F, 13);
        run_single("clamp_15", 15, 0, 13'h0F0F);
        encode(1, 1);
        run_single("clamp_0", 0, 0, 1);
        check("no_overflow_yet", int'(ovf), 0);

        // Three back-to-back 13-bit frames: the third is dropped.
        clear_q();
        i1 = $urandom_range(0, 8191);
        i2 = $urandom_range(0, 8191);
        encode(i1, 13);
        model(13, w1, m1);
        drive_frame(13, 20, 0);
        encode(i2, 13);
        model(13, w2, m2);
        drive_frame(13, 20, 0);
        encode($urandom_range(0, 8191), 13);
        drive_frame(13, 20, 0);
        idle(5);
        check("overflow_set", int'(ovf), 1);
        wait_strobes(2, 16500);
        if (got_bits.size() >= 2) begin
            check("ovf_word1", got_bits[0], w1);
            check("ovf_word2", got_bits[1], w2);
            check("ovf_word1_info", got_bits[0], i1);
            check("ovf_word2_info", got_bits[1], i2);
        end
        idle(8300);
        check("ovf_strobe_count", got_bits.size(), 2);
        check("overflow_sticky", int'(ovf), 1);

        do_reset();
        check("overflow_cleared", int'(ovf), 0);

        // Reset in the middle of a frame, then a complete one.
        encode(13'h15, 5);
        drive_frame(5, 10, 0);
        do_reset();
        encode(13'h0A, 5);
        run_single("after_mid_reset", 5, 0, 13'h0A);

        // Random soft symbols, random lengths, random gaps.
        for (int t = 0; t < 8; t++) begin
            a = $urandom_range(0, 8);
            for (int n = 0; n < 20; n++) sym[n] = int'($urandom_range(0, 15)) - 8;
            run_single($sformatf("rand%0d", t), a, 1, -1);
        end
        check("final_overflow", int'(ovf), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
